// File: rtl/mem_bist_ctrl_pkg.sv
// Shared types and constants for the memory BIST controller.
// FSM states, pattern selects and checkerboard seed bytes.
package mem_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CMP,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_ZERO,
    PAT_ONES,
    PAT_CHECK,
    PAT_ADDR
  } pattern_e;

  localparam logic [7:0] CHK_EVEN = 8'h55;
  localparam logic [7:0] CHK_ODD  = 8'hAA;

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// Memory command/data bus between the BIST controller and the RAM.
// master = controller side, slave = memory side.
interface mem_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/bist_pattern_gen.sv
// Expected-word generator for the BIST patterns.
// Purely combinational; one copy feeds writes, one feeds compares.
module bist_pattern_gen
  import mem_bist_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  pattern_e              pattern_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = '0;
    unique case (pattern_i)
      PAT_ZERO: data_o = '0;
      PAT_ONES: data_o = '1;
      PAT_CHECK: begin
        // seed byte repeated across the whole word
        for (int i = 0; i < DATA_WIDTH; i++) begin
          data_o[i] = addr_i[0] ? CHK_ODD[3'(i)]
                                : CHK_EVEN[3'(i)];
        end
      end
      PAT_ADDR: data_o = DATA_WIDTH'(addr_i);
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style write-all / read-compare-all memory BIST controller.
// All outputs come straight from flops; mem_rdata only feeds state.
module mem_bist_ctrl
  import mem_bist_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int ERR_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  mem_bist_ctrl_if.master       mem
);

  localparam logic [ADDR_WIDTH-1:0] A_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] A_ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_WIDTH-1:0] E_MAX = '1;
  localparam logic [ERR_WIDTH-1:0] E_ONE =
    {{(ERR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q;
  pattern_e              pat_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [ERR_WIDTH-1:0]  err_q;
  logic [ADDR_WIDTH-1:0] faddr_q;
  logic [DATA_WIDTH-1:0] fdata_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  pattern_e              wr_pat_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_exp;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic                  mism;

  // write data is computed for the address being issued next cycle
  assign wr_pat_d  = (state_q == ST_IDLE) ? pattern_e'(pattern)
                                          : pat_q;
  assign wr_addr_d = (state_q == ST_IDLE) ? '0 : cnt_q + A_ONE;
  assign mism      = (mem.mem_rdata != cmp_exp);

  bist_pattern_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gen_wr (
    .pattern_i (wr_pat_d),
    .addr_i    (wr_addr_d),
    .data_o    (wr_exp)
  );

  bist_pattern_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gen_cmp (
    .pattern_i (pat_q),
    .addr_i    (cnt_q),
    .data_o    (cmp_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_ZERO;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_WRITE;
            pat_q   <= wr_pat_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b1;
            err_q   <= '0;
            faddr_q <= '0;
            fdata_q <= '0;
            wr_q    <= 1'b1;
            addr_q  <= wr_addr_d;
            wdata_q <= wr_exp;
          end
        end
        ST_WRITE: begin
          if (cnt_q == A_LAST) begin
            state_q <= ST_READ;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
          end else begin
            cnt_q   <= wr_addr_d;
            addr_q  <= wr_addr_d;
            wdata_q <= wr_exp;
          end
        end
        ST_READ: begin
          state_q <= ST_CMP;
          rd_q    <= 1'b0;
        end
        ST_CMP: begin
          if (mism) begin
            pass_q <= 1'b0;
            if (err_q != E_MAX) err_q <= err_q + E_ONE;
            // pass still high means this is the first miss
            if (pass_q) begin
              faddr_q <= cnt_q;
              fdata_q <= mem.mem_rdata;
            end
          end
          if (cnt_q == A_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_READ;
            cnt_q   <= cnt_q + A_ONE;
            rd_q    <= 1'b1;
            addr_q  <= cnt_q + A_ONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign fail_addr     = faddr_q;
  assign fail_data     = fdata_q;
  assign mem.mem_read  = rd_q;
  assign mem.mem_write = wr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl with a faultable 32x8 RAM.
// Expected writes/results come from a per-address reference model.
module tb_mem_bist_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    pattern = 2'd0;
  logic          busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  logic          start2 = 1'b0;
  logic [1:0]    pattern2 = 2'd3;
  logic          busy2, done2, pass2;
  logic [2:0]    err2;
  logic [AW-1:0] faddr2;
  logic [DW-1:0] fdata2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  mem_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m ();
  mem_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m2 ();

  mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pattern   (pattern),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .mem       (m)
  );

  mem_bist_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_WIDTH(3)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .pattern   (pattern2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .err_count (err2),
    .fail_addr (faddr2),
    .fail_data (fdata2),
    .mem       (m2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem   [N];
  logic [7:0] mem2  [N];
  logic [7:0] and_m [N];
  logic [7:0] or_m  [N];
  logic [7:0] xor_m [N];

  always @(posedge clk) begin
    if (m.mem_write) mem[m.mem_addr] <= m.mem_wdata;
    if (m.mem_read)
      m.mem_rdata <= ((mem[m.mem_addr] & and_m[m.mem_addr])
                     | or_m[m.mem_addr]) ^ xor_m[m.mem_addr];
  end

  // second RAM returns every word inverted
  always @(posedge clk) begin
    if (m2.mem_write) mem2[m2.mem_addr] <= m2.mem_wdata;
    if (m2.mem_read) m2.mem_rdata <= ~mem2[m2.mem_addr];
  end

  typedef struct { int a; int d; } wr_t;
  typedef struct { int ps; int ec; int fa; int fd; int cy; } res_t;

  wr_t  wq[$];
  res_t rq[$];
  wr_t  w_m;
  res_t r_m;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cyc %0d)", nm, cyc);
  endtask

  function automatic int exp_word(input int p, input int a);
    case (p)
      0:       return 0;
      1:       return 255;
      2:       return (a % 2 == 1) ? 170 : 85;
      default: return a % 256;
    endcase
  endfunction

  // what a run with pattern p over the current fault masks yields
  task automatic model(input int p, output res_t r);
    int e;
    int rd;
    r = '{1, 0, 0, 0, 0};
    for (int a = 0; a < N; a++) begin
      e  = exp_word(p, a);
      wq.push_back('{a, e});
      rd = ((e & int'(and_m[a])) | int'(or_m[a])) ^ int'(xor_m[a]);
      if (rd != e) begin
        if (r.ps == 1) begin
          r.fa = a;
          r.fd = rd;
        end
        r.ps = 0;
        if (r.ec < 63) r.ec++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m.mem_read || m.mem_write)
        chk("rw_excl", 32'(m.mem_read & m.mem_write), 0);
      if (m.mem_write) begin
        if (wq.size() == 0) note_fail("wr_unexp");
        else begin
          w_m = wq.pop_front();
          chk("wr_addr", 32'(m.mem_addr), w_m.a);
          chk("wr_data", 32'(m.mem_wdata), w_m.d);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_1cyc", 32'(done_prev), 0);
        if (rq.size() == 0) note_fail("done_unexp");
        else begin
          r_m = rq.pop_front();
          chk("pass", 32'(pass), r_m.ps);
          chk("err_count", 32'(err_count), r_m.ec);
          chk("fail_addr", 32'(fail_addr), r_m.fa);
          chk("fail_data", 32'(fail_data), r_m.fd);
          chk("done_cyc", cyc, r_m.cy);
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic clr_faults();
    for (int a = 0; a < N; a++) begin
      and_m[a] = 8'hFF;
      or_m[a]  = 8'h00;
      xor_m[a] = 8'h00;
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"},
        32'({busy, done, pass, m.mem_read, m.mem_write}), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_fail"}, 32'({fail_addr, fail_data}), 0);
    chk({tag, "_bus"}, 32'({m.mem_addr, m.mem_wdata}), 0);
  endtask

  task automatic launch(input int p);
    res_t r;
    model(p, r);
    @(negedge clk);
    start   = 1'b1;
    pattern = 2'(p);
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
    r.cy  = t0 + 96;
    rq.push_back(r);
    chk("busy_rise", 32'(busy), 1);
  endtask

  task automatic wait_done();
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1;
    end
    if (!seen) note_fail("done_timeout");
    @(negedge clk);
    chk("busy_after", 32'({busy, done}), 0);
  endtask

  task automatic run(input int p);
    launch(p);
    wait_done();
  endtask

  initial begin
    int d0;
    int nf;
    int fa;
    bit seen;
    clr_faults();
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    @(negedge clk);

    clr_faults();
    run(2);

    clr_faults();
    and_m[10] = 8'hF7;
    run(1);

    clr_faults();
    or_m[4]  = 8'h80;
    or_m[31] = 8'h80;
    run(3);

    clr_faults();
    launch(1);
    while (cyc < t0 + 39) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rst("midrst");
    wq.delete();
    rq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    clr_faults();
    d0 = done_cnt;
    launch(3);
    while (cyc < t0 + 50) @(negedge clk);
    start   = 1'b1;
    pattern = 2'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("one_done", done_cnt - d0, 1);
    chk("busy_idle", 32'(busy), 0);

    clr_faults();
    for (int a = 0; a < N; a++) xor_m[a] = 8'hFF;
    run(0);

    repeat (6) begin
      clr_faults();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        fa = $urandom_range(0, N - 1);
        case ($urandom_range(0, 2))
          0:       and_m[fa] = ~(8'h01 << $urandom_range(0, 7));
          1:       or_m[fa]  = 8'h01 << $urandom_range(0, 7);
          default: xor_m[fa] = 8'($urandom_range(1, 255));
        endcase
      end
      run($urandom_range(0, 3));
    end

    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    seen   = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done2) seen = 1;
    end
    chk("sat_done", 32'(done2), 1);
    chk("sat_err", 32'(err2), 7);
    chk("sat_pass", 32'(pass2), 0);
    chk("sat_faddr", 32'(faddr2), 0);
    chk("sat_fdata", 32'(fdata2), 255);

    repeat (5) @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a test run; sampled only in IDLE.
REQ-006 pattern  input  2  test pattern select; latched at start.
REQ-007 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-008 done  output  1  high for exactly one cycle at end of run.
REQ-009 pass  output  1  result of the last run; valid once done has been seen.
REQ-010 err_count  output  ADDR_WIDTH+1  number of mismatching addresses in the last run.
REQ-011 fail_addr  output  ADDR_WIDTH  address of the first mismatch.
REQ-012 fail_data  output  DATA_WIDTH  read data at the first mismatch.
REQ-013 mem_read, mem_write  output  1 each  memory command strobes, drive the memory's read/write.
REQ-014 mem_addr  output  ADDR_WIDTH  memory address.
REQ-015 mem_wdata  output  DATA_WIDTH  memory write data, drives data_in.
REQ-016 mem_rdata  input  DATA_WIDTH  memory read data, from data_out.

Function
REQ-017 SHALL implement the FSM states IDLE, WRITE, READ, CMP and DONE.
REQ-018 IDLE: start=1 -> WRITE; latch pattern; clear err_count to 0; set pass=1; set address counter to 0.
REQ-019 WRITE: mem_write=1 with mem_addr=counter and mem_wdata=expected(counter); increment counter; at the last address (2^ADDR_WIDTH-1) wrap the counter to 0 and go to READ.
REQ-020 READ: mem_read=1 with mem_addr=counter for one cycle -> CMP; memory read latency is one cycle (mem_rdata is valid in CMP).
REQ-021 CMP: compare mem_rdata with expected(counter); on the last address go to DONE, otherwise increment the counter and go to READ.
REQ-022 Expected data SHALL be defined per pattern:
- 0: all zeros.
- 1: all ones.
- 2: checkerboard, 0x55.. at even addresses and 0xAA.. at odd addresses (replicated to DATA_WIDTH).
- 3: the address zero-extended or truncated to DATA_WIDTH.
REQ-023 On a mismatch: increment err_count and clear pass; on the first mismatch only, capture fail_addr and fail_data.
REQ-024 err_count SHALL saturate at its maximum and never wrap.
REQ-025 DONE: done=1 for one cycle, then return to IDLE; pass, err_count, fail_addr and fail_data hold until the next accepted start.
REQ-026 start outside IDLE SHALL be ignored, with no restart; start held high in IDLE after DONE starts a new run.
REQ-027 mem_read and mem_write SHALL never be high in the same cycle; both are 0 in IDLE, CMP and DONE.
REQ-028 Latency: start sampled in cycle T -> first write in T+1; done in cycle T+1+3*2^ADDR_WIDTH (T+97 at defaults).
REQ-029 All outputs SHALL be registered or decoded from registered state only, with no combinational path from mem_rdata to outputs.

Reset
REQ-030 rst_n low at any time, including mid-run, SHALL immediately force:
- state IDLE; counter 0;
- busy, done, mem_read, mem_write = 0;
- mem_addr, mem_wdata, err_count, fail_addr, fail_data = 0;
- pass = 0.
REQ-031 Memory contents are not guaranteed after a reset mid-run; the first run after reset starts cleanly from address 0.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the pattern-select enum (PAT_ZERO, PAT_ONES, PAT_CHECK, PAT_ADDR) and the checkerboard constants.
REQ-033 The expected-data generator SHALL be one combinational sub-module, bist_pattern_gen (inputs pattern and address, output expected word), instantiated for both the write and compare paths.

Verification
REQ-034 The bench SHALL cover these directed scenarios, using a behavioural 32x8 memory model with 1-cycle read latency:
- Fault-free memory, pattern=2 -> done at T+97; pass=1; err_count=0; 32 writes of alternating 0x55/0xAA.
- Memory with a stuck-at-0 fault on bit 3 at address 0x0A, pattern=1 -> pass=0; err_count=1; fail_addr=0x0A; fail_data=0xF7.
- Faults at addresses 0x04 and 0x1F, pattern=3 -> err_count=2; fail_addr=0x04 (first only).
- rst_n pulsed low at T+40 -> all outputs reset within the same cycle; a new start completes with pass=1.
- start pulsed during READ -> ignored; exactly one done pulse; busy low after DONE.
- A model that forces every read to mismatch, with ADDR_WIDTH=5 -> err_count=32, no overflow; a saturation check with a reduced err_count width.
